// File: rtl/tdc_spi_master_if.sv
// tdc_spi_master_if: byte handshake between tdc_control and the SPI master
interface tdc_spi_master_if;
    logic       start;
    logic [7:0] data_in;
    logic       cs_end;
    logic [7:0] data_out;
    logic       new_data;
    logic       busy;
    modport master (output start, data_in, cs_end, input data_out, new_data, busy);
    modport slave (input start, data_in, cs_end, output data_out, new_data, busy);
endinterface

// File: rtl/tdc_spi_master.sv
// tdc_spi_master: byte-wise mode-0 SPI master with chip-select framing for the TDC7200
module tdc_spi_master #(
    parameter int CLK_DIV      = 2,
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_HOLD_CYC  = 2,
    parameter int CS_IDLE_CYC  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    tdc_spi_master_if.slave  bus,
    output logic             sck,
    output logic             mosi,
    input  logic             miso,
    output logic             cs_n
);
    localparam int M1   = CLK_DIV > CS_SETUP_CYC ? CLK_DIV : CS_SETUP_CYC;
    localparam int M2   = M1 > CS_HOLD_CYC ? M1 : CS_HOLD_CYC;
    localparam int CMAX = M2 > CS_IDLE_CYC ? M2 : CS_IDLE_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] DIV_LD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SET_LD = CW'(CS_SETUP_CYC - 1);
    localparam logic [CW-1:0] HLD_LD = CW'(CS_HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(CS_IDLE_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [2:0]      bit_cnt, bit_d;
    logic [7:0]      tx, tx_d, rx, rx_d, dout, dout_d;
    logic            mosi_d, sck_d, cs_n_d, busy, busy_d, nd, nd_d, last, last_d;
    logic            rise_p, rise_p_d, rise_s, alive, m1, m2;

    assign bus.busy     = busy;
    assign bus.new_data = nd;
    assign bus.data_out = dout;

    // miso synchroniser; rise strobe delayed to line up with it; alive blocks start on reset release
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m1     <= 1'b0;
            m2     <= 1'b0;
            rise_s <= 1'b0;
            alive  <= 1'b0;
        end else begin
            m1     <= miso;
            m2     <= m1;
            rise_s <= rise_p;
            alive  <= 1'b1;
        end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            tx      <= '0;
            rx      <= '0;
            dout    <= '0;
            mosi    <= 1'b0;
            sck     <= 1'b0;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            nd      <= 1'b0;
            last    <= 1'b0;
            rise_p  <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_cnt <= bit_d;
            tx      <= tx_d;
            rx      <= rx_d;
            dout    <= dout_d;
            mosi    <= mosi_d;
            sck     <= sck_d;
            cs_n    <= cs_n_d;
            busy    <= busy_d;
            nd      <= nd_d;
            last    <= last_d;
            rise_p  <= rise_p_d;
        end

    // next-state: rx samples the synchronised miso two cycles after each SCK rise
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        bit_d    = bit_cnt;
        tx_d     = tx;
        rx_d     = rise_s ? {rx[6:0], m2} : rx;
        dout_d   = dout;
        mosi_d   = mosi;
        sck_d    = sck;
        cs_n_d   = cs_n;
        busy_d   = busy;
        nd_d     = 1'b0;
        last_d   = last;
        rise_p_d = 1'b0;
        case (state)
            IDLE:
                if (bus.start && alive) begin
                    state_d = SETUP;
                    busy_d  = 1'b1;
                    tx_d    = bus.data_in;
                    mosi_d  = bus.data_in[7];
                    last_d  = bus.cs_end;
                    cs_n_d  = 1'b0;
                    cnt_d   = cs_n ? SET_LD : '0;
                end
            SETUP: begin
                cnt_d = cnt - ONE;
                if (cnt == '0) begin
                    state_d  = XFER;
                    sck_d    = 1'b1;
                    rise_p_d = 1'b1;
                    cnt_d    = DIV_LD;
                    bit_d    = '0;
                end
            end
            XFER:
                if (sck) begin
                    cnt_d = cnt - ONE;
                    if (cnt == '0) begin
                        sck_d = 1'b0;
                        cnt_d = DIV_LD;
                        if (bit_cnt != 3'd7) begin
                            tx_d   = {tx[6:0], 1'b0};
                            mosi_d = tx[6];
                        end
                    end
                end else if (bit_cnt == 3'd7) begin
                    nd_d    = 1'b1;
                    dout_d  = rx_d;
                    busy_d  = last;
                    state_d = last ? HOLD : IDLE;
                    cnt_d   = HLD_LD;
                end else begin
                    cnt_d = cnt - ONE;
                    if (cnt == '0) begin
                        sck_d    = 1'b1;
                        rise_p_d = 1'b1;
                        cnt_d    = DIV_LD;
                        bit_d    = bit_cnt + 3'd1;
                    end
                end
            HOLD: begin
                cnt_d = cnt - ONE;
                if (cnt == '0) begin
                    cs_n_d  = 1'b1;
                    state_d = GAP;
                    cnt_d   = GAP_LD;
                end
            end
            GAP: begin
                cnt_d = cnt - ONE;
                if (cnt == '0) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tdc_spi_master.sv
// tb_tdc_spi_master: directed bench for tdc_spi_master at CLK_DIV 2, 1 and 5
module tb_tdc_spi_master;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] data_in;
    logic       cs_end;
    logic [7:0] slv_next;
    logic       sck_v [3];
    logic       mosi_v [3];
    logic       miso_v [3];
    logic       cs_v [3];
    logic       busy_v [3];
    logic       nd_v [3];
    logic [7:0] dout_v [3];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         first_rise [3], rise_c [3], nd_c [3], csr_c [3], bzf_c [3];
    int         nd_cnt [3], csf_cnt [3], hbad [3], bi [3], bc [3];
    bit         psck [3], pcs [3], pbz [3];
    bit [7:0]   sh [3], mcap [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int D = g == 0 ? 2 : g == 1 ? 1 : 5;
        tdc_spi_master_if b ();
        assign b.start   = start;
        assign b.data_in = data_in;
        assign b.cs_end  = cs_end;
        assign busy_v[g] = b.busy;
        assign nd_v[g]   = b.new_data;
        assign dout_v[g] = b.data_out;
        tdc_spi_master #(.CLK_DIV(D)) u (
            .clk(clk), .rst_n(rst_n), .bus(b),
            .sck(sck_v[g]), .mosi(mosi_v[g]), .miso(miso_v[g]), .cs_n(cs_v[g])
        );
    end

    function automatic int dv(input int i);
        return i == 0 ? 2 : i == 1 ? 1 : 5;
    endfunction

    // mode-0 slave model plus edge/timing monitors, all sampled mid-cycle
    always @(negedge clk)
        for (int i = 0; i < 3; i++) begin
            if (cs_v[i]) bc[i] = 0;
            else if (pcs[i]) begin
                sh[i] = slv_next;
                bc[i] = 0;
                csf_cnt[i]++;
            end else if (psck[i] && !sck_v[i]) begin
                bc[i]++;
                if (bc[i] == 8) begin
                    sh[i] = slv_next;
                    bc[i] = 0;
                end else sh[i] = {sh[i][6:0], 1'b0};
            end
            miso_v[i] = sh[i][7];
            if (sck_v[i] && !psck[i]) begin
                if (bi[i] > 0 && cyc - rise_c[i] != 2 * dv(i)) hbad[i]++;
                if (bi[i] == 0) first_rise[i] = cyc;
                rise_c[i] = cyc;
                bi[i]++;
                mcap[i] = {mcap[i][6:0], mosi_v[i]};
            end
            if (!sck_v[i] && psck[i] && !cs_v[i] && cyc - rise_c[i] != dv(i)) hbad[i]++;
            if (nd_v[i]) begin
                nd_cnt[i]++;
                nd_c[i] = cyc;
                bi[i] = 0;
            end
            if (cs_v[i] && !pcs[i]) begin
                csr_c[i] = cyc;
                bi[i] = 0;
            end
            if (!busy_v[i] && pbz[i]) bzf_c[i] = cyc;
            psck[i] = sck_v[i];
            pcs[i]  = cs_v[i];
            pbz[i]  = busy_v[i];
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] d, input logic e, output int t);
        data_in = d;
        cs_end  = e;
        start   = 1'b1;
        t       = cyc;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_idle(input logic [2:0] m);
        int n = 0;
        while (((m[0] & busy_v[0]) | (m[1] & busy_v[1]) | (m[2] & busy_v[2])) && n < 400) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", 32'(n >= 400), 0);
    endtask

    initial begin
        int t, t2, n0, c0;
        logic [7:0] e;
        rst_n = 1'b0; start = 1'b0; data_in = '0; cs_end = 1'b0; slv_next = '0;
        repeat (3) tick();
        chk("rst_cs_n", cs_v[0], 1);
        chk("rst_sck", sck_v[0], 0);
        chk("rst_mosi", mosi_v[0], 0);
        chk("rst_busy", busy_v[0], 0);
        chk("rst_new_data", nd_v[0], 0);
        chk("rst_data_out", dout_v[0], 8'h00);
        // start coincident with reset release is dropped
        rst_n = 1'b1; start = 1'b1; data_in = 8'hEE; cs_end = 1'b1;
        tick();
        start = 1'b0;
        chk("rel_start_busy", busy_v[0], 0);
        chk("rel_start_cs_n", cs_v[0], 1);
        tick();
        chk("rel_start_busy2", busy_v[0], 0);

        // single framed byte
        slv_next = 8'h3C;
        n0 = nd_cnt[0];
        pulse(8'hA5, 1'b1, t);
        chk("t1_busy_T1", busy_v[0], 1);
        chk("t1_cs_T1", cs_v[0], 0);
        wait_idle(3'b001);
        tick();
        chk("t1_mosi_bits", mcap[0], 8'hA5);
        chk("t1_data_out", dout_v[0], 8'h3C);
        chk("t1_nd_time", nd_c[0] - t, 34);
        chk("t1_nd_count", nd_cnt[0] - n0, 1);
        chk("t1_first_rise", first_rise[0] - t, 3);
        chk("t1_cs_rise", csr_c[0] - t, 36);
        chk("t1_busy_fall", bzf_c[0] - t, 40);
        chk("t1_hbad", hbad[0], 0);

        // two-byte frame, cs held low between bytes
        slv_next = 8'h55;
        n0 = nd_cnt[0];
        c0 = csf_cnt[0];
        pulse(8'h01, 1'b0, t);
        tick();
        tick();
        slv_next = 8'hAA;
        wait_idle(3'b001);
        chk("t2_b1_busy_time", cyc - t, 34);
        chk("t2_b1_nd", nd_v[0], 1);
        chk("t2_b1_data", dout_v[0], 8'h55);
        chk("t2_b1_cs_low", cs_v[0], 0);
        chk("t2_b1_mosi", mcap[0], 8'h01);
        tick();
        pulse(8'h0F, 1'b1, t2);
        wait_idle(3'b001);
        tick();
        chk("t2_b2_first_rise", first_rise[0] - t2, 2);
        chk("t2_b2_data", dout_v[0], 8'hAA);
        chk("t2_b2_mosi", mcap[0], 8'h0F);
        chk("t2_cs_windows", csf_cnt[0] - c0, 1);
        chk("t2_nd_count", nd_cnt[0] - n0, 2);

        // tdc_control handshake: 18 bytes, cs_end on every second byte
        n0 = nd_cnt[0];
        c0 = csf_cnt[0];
        slv_next = 8'(37);
        for (int j = 0; j < 18; j++) begin
            pulse(8'(j), j % 2 == 1, t);
            tick();
            tick();
            slv_next = 8'((j + 2) * 37);
            wait_idle(3'b001);
            e = 8'((j + 1) * 37);
            chk($sformatf("t3_byte%0d", j), dout_v[0], e);
        end
        tick();
        chk("t3_cs_windows", csf_cnt[0] - c0, 9);
        chk("t3_nd_count", nd_cnt[0] - n0, 18);

        // start while busy is ignored
        slv_next = 8'h96;
        n0 = nd_cnt[0];
        pulse(8'h5A, 1'b1, t);
        while (cyc < t + 10) tick();
        data_in = 8'hFF; cs_end = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(3'b001);
        tick();
        chk("t4_mosi_bits", mcap[0], 8'h5A);
        chk("t4_data_out", dout_v[0], 8'h96);
        chk("t4_nd_count", nd_cnt[0] - n0, 1);
        chk("t4_busy_fall", bzf_c[0] - t, 40);
        repeat (3) tick();
        chk("t4_no_queue", busy_v[0], 0);

        // asynchronous reset at the 4th SCK rise
        slv_next = 8'h77;
        pulse(8'hC3, 1'b1, t);
        while (cyc < t + 15) tick();
        chk("t5_sck_pre", sck_v[0], 1);
        n0 = nd_cnt[0];
        rst_n = 1'b0;
        #1;
        chk("t5_cs_n", cs_v[0], 1);
        chk("t5_sck", sck_v[0], 0);
        chk("t5_busy", busy_v[0], 0);
        chk("t5_nd", nd_v[0], 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("t5_no_partial_nd", nd_cnt[0] - n0, 0);
        chk("t5_data_out_clr", dout_v[0], 8'h00);
        slv_next = 8'h5A;
        pulse(8'h81, 1'b1, t);
        wait_idle(3'b111);
        tick();
        chk("t5_mosi_bits", mcap[0], 8'h81);
        chk("t5_data_out", dout_v[0], 8'h5A);
        chk("t5_nd_time", nd_c[0] - t, 34);

        // CLK_DIV sweep on the div-1 and div-5 instances
        slv_next = 8'hC3;
        pulse(8'h3C, 1'b1, t);
        wait_idle(3'b111);
        tick();
        chk("t6_div1_data", dout_v[1], 8'hC3);
        chk("t6_div5_data", dout_v[2], 8'hC3);
        chk("t6_div1_mosi", mcap[1], 8'h3C);
        chk("t6_div5_mosi", mcap[2], 8'h3C);
        chk("t6_div1_first_rise", first_rise[1] - t, 3);
        chk("t6_div5_first_rise", first_rise[2] - t, 3);
        chk("t6_div1_nd_time", nd_c[1] - t, 19);
        chk("t6_div5_nd_time", nd_c[2] - t, 79);
        chk("t6_div1_halfper", hbad[1], 0);
        chk("t6_div5_halfper", hbad[2], 0);
        chk("t6_div2_halfper", hbad[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tdc_spi_master.md
Name: tdc_spi_master

Overview:
- Byte-wise SPI master (mode 0, MSB first) between tdc_control and the TDC7200 pins.
- tdc_control supplies one MOSI byte per start pulse and a per-byte CS_END flag; this block shifts the byte, returns the MISO byte, and frames chip-select.
- The busy output is the tdc_busy input of tdc_control. The control FSM relies on busy being high in the cycle after its one-cycle start pulse.

Parameters:
- CLK_DIV, 2: clk cycles per SCK half-period, legal range 1..255.
- CS_SETUP_CYC, 2: cycles from cs_n falling to the first SCK rise, legal range 1..15.
- CS_HOLD_CYC, 2: cycles from the last SCK fall to cs_n rising, legal range 1..15.
- CS_IDLE_CYC, 4: minimum cs_n-high cycles before the next frame, held under busy, legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only when busy=0
- data_in  in  8  MOSI byte; captured with start
- cs_end  in  1  captured with start; 1 means deassert cs_n after this byte
- data_out  out  8  last received MISO byte
- new_data  out  1  one-cycle pulse when data_out updates
- busy  out  1  transfer, hold or idle-gap in progress
- sck  out  1  SPI clock, idles low
- mosi  out  1  SPI data out
- miso  in  1  SPI data in, double-flop synchronised internally
- cs_n  out  1  chip select, active low

Behaviour:
- Reset (asynchronous, rst_n=0):
  - cs_n=1, sck=0, mosi=0, busy=0, new_data=0, data_out=8'h00, FSM=IDLE.
  - Applies immediately even mid-frame; no partial new_data is issued.
- All outputs are registered.
- IDLE, start=1 at cycle T: at T+1, busy=1, the shift register loads data_in, mosi=data_in[7], and cs_end is latched.
  - If cs_n was 1: cs_n=0 at T+1, go to SETUP for CS_SETUP_CYC cycles.
  - If cs_n was already 0 (previous byte had cs_end=0): SETUP lasts 1 cycle.
- TRANSFER, 8 bits:
  - Per bit: sck high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - On each rising edge, sample synchronised miso into the RX shift register (LSB in).
  - On each falling edge except the 8th, shift mosi to the next bit.
- End of byte: in the cycle after the 8th SCK fall, data_out=RX byte and new_data=1 for exactly 1 cycle.
- With latched cs_end=0:
  - busy=0 in the same cycle as new_data.
  - cs_n stays 0, sck=0, mosi holds bit 0; return to IDLE.
- With latched cs_end=1:
  - HOLD for CS_HOLD_CYC cycles, then cs_n=1.
  - GAP for CS_IDLE_CYC cycles, then busy=0 and IDLE.
- Default timing, new frame (start at T): cs_n=0 at T+1; SCK rises at T+3+4k and falls at T+5+4k, k=0..7; new_data at T+34.
  - cs_end=0: busy=0 at T+34.
  - cs_end=1: cs_n=1 at T+36, busy=0 at T+40.
- start while busy=1: ignored; no queuing; data_in and cs_end are not captured.
- start and reset release in the same cycle: start is ignored (FSM not yet out of reset).
- CS_SETUP_CYC and CS_HOLD_CYC apply only to frame edges, never between bytes inside a frame.
- Counter widths sized from the parameters; no wrap during a legal frame.

Test Plan:
- Single framed byte: start with data_in=8'hA5, cs_end=1, slave returns 8'h3C.
  - mosi bits 1,0,1,0,0,1,0,1 valid at each SCK rise.
  - data_out=8'h3C, one new_data pulse at T+34.
  - cs_n low T+1..T+35; busy low at T+40.
- Two-byte frame:
  - Byte 1 = 8'h01 with cs_end=0; at T+34 busy=0 and cs_n stays 0.
  - Byte 2 = 8'h0F with cs_end=1, start one cycle later: first SCK rise 2 cycles after that start.
  - cs_n stays low continuously; two new_data pulses carry MISO bytes 8'h55 and 8'hAA.
- Busy protocol with a model of the tdc_control handshake (start pulse, then wait on !busy and start low):
  - Issue 18 bytes, CS_END on every 2nd byte.
  - Exactly 9 cs_n low windows, 18 new_data pulses, no byte skipped.
- start pulsed at T+10 during a transfer with data_in=8'hFF: ignored; the mosi sequence and data_out of the current byte are unchanged.
- rst_n driven low at the 4th SCK rise:
  - Same cycle: cs_n=1, sck=0, busy=0, no new_data.
  - After release, a start with 8'h81 completes normally.
- Parameter sweep with CLK_DIV=1 and CLK_DIV=5: SCK half-period equals CLK_DIV cycles; received byte 8'hC3 is returned correctly in both cases.
